// File: rtl/pcs_rx_pkg.sv
// -----------------------------------------------------------------------------
// pcs_rx_pkg
// Shared definitions for the PCS receive path: sync-header codes, default
// limits used as parameter defaults, the per-lane lock state encoding and a
// helper that classifies a 2-bit sync header.
// -----------------------------------------------------------------------------
package pcs_rx_pkg;

    // Legal 64b/66b sync headers: data block and control block.
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Default structural parameters and limits.
    localparam int DEF_N_LANES                = 20;
    localparam int DEF_NB_DATA                = 66;
    localparam int DEF_VALID_COUNT_LIMIT_SLOW = 40;
    localparam int DEF_NB_WINDOW_CNT          = 12;
    localparam int DEF_NB_INV_SH              = 11;
    localparam int DEF_HI_BER_VALUE           = 97;
    localparam int DEF_XUS_TIMER_WINDOW       = 1024;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

    // A header is valid only when its two bits differ.
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_toplevel_if.sv
// -----------------------------------------------------------------------------
// rx_toplevel_if
// Per-lane link between the receive top level and one block-sync lane.
//   master (top level): drives block strobe, sync header, forced unlock and
//                       the programmable limits; reads lock and hi-BER status.
//   slave  (lane)     : the reverse.
// -----------------------------------------------------------------------------
interface rx_toplevel_if #(
    parameter int NB_WINDOW_CNT = 12,
    parameter int NB_INV_SH     = 11
);
    logic                     blk_valid_s;
    logic [1:0]               sync_header_s;
    logic                     force_unlock_s;
    logic [NB_WINDOW_CNT-1:0] unlocked_limit_s;
    logic [NB_WINDOW_CNT-1:0] locked_limit_s;
    logic [NB_INV_SH-1:0]     sh_invalid_limit_s;
    logic                     lane_locked_s;
    logic                     hi_ber_status_s;

    modport master (
        output blk_valid_s, sync_header_s, force_unlock_s,
               unlocked_limit_s, locked_limit_s, sh_invalid_limit_s,
        input  lane_locked_s, hi_ber_status_s
    );

    modport slave (
        input  blk_valid_s, sync_header_s, force_unlock_s,
               unlocked_limit_s, locked_limit_s, sh_invalid_limit_s,
        output lane_locked_s, hi_ber_status_s
    );
endinterface

// File: rtl/rx_lane_block_sync.sv
// -----------------------------------------------------------------------------
// rx_lane_block_sync
// One PCS lane: block-lock FSM (UNLOCKED/LOCKED) plus BER monitor.
// Ports:
//   i_clock  - rising-edge clock
//   i_reset  - synchronous active-low reset
//   lane_if  - slave side of rx_toplevel_if (strobe, header, limits in;
//              lock and hi-BER status out, both straight from registers)
// State only advances on lane_if.blk_valid_s; a forced unlock acts every clock.
// -----------------------------------------------------------------------------
module rx_lane_block_sync
    import pcs_rx_pkg::*;
#(
    parameter int NB_WINDOW_CNT    = DEF_NB_WINDOW_CNT,
    parameter int NB_INV_SH        = DEF_NB_INV_SH,
    parameter int HI_BER_VALUE     = DEF_HI_BER_VALUE,
    parameter int XUS_TIMER_WINDOW = DEF_XUS_TIMER_WINDOW
) (
    input  logic         i_clock,
    input  logic         i_reset,
    rx_toplevel_if.slave lane_if
);

    localparam int NB_BER_WIN = $clog2(XUS_TIMER_WINDOW + 1);
    localparam int NB_BER_CNT = $clog2(HI_BER_VALUE + 1);

    localparam logic [NB_WINDOW_CNT-1:0] WIN_ZERO    = {NB_WINDOW_CNT{1'b0}};
    localparam logic [NB_WINDOW_CNT-1:0] WIN_ONE     = NB_WINDOW_CNT'(1'b1);
    localparam logic [NB_INV_SH-1:0]     INV_ZERO    = {NB_INV_SH{1'b0}};
    localparam logic [NB_INV_SH-1:0]     INV_ONE     = NB_INV_SH'(1'b1);
    localparam logic [NB_BER_WIN-1:0]    BWIN_ZERO   = {NB_BER_WIN{1'b0}};
    localparam logic [NB_BER_WIN-1:0]    BWIN_ONE    = NB_BER_WIN'(1'b1);
    localparam logic [NB_BER_WIN-1:0]    BWIN_LAST   = NB_BER_WIN'(XUS_TIMER_WINDOW - 1);
    localparam logic [NB_BER_CNT-1:0]    BCNT_ZERO   = {NB_BER_CNT{1'b0}};
    localparam logic [NB_BER_CNT-1:0]    BCNT_ONE    = NB_BER_CNT'(1'b1);
    localparam logic [NB_BER_CNT-1:0]    BCNT_THRESH = NB_BER_CNT'(HI_BER_VALUE);

    lock_state_e              state_r,   state_nxt_s;
    logic [NB_WINDOW_CNT-1:0] good_cnt_r, good_nxt_s, good_inc_s;
    logic [NB_WINDOW_CNT-1:0] win_cnt_r,  win_nxt_s,  win_inc_s;
    logic [NB_INV_SH-1:0]     inv_cnt_r,  inv_nxt_s,  inv_inc_s;
    logic [NB_BER_WIN-1:0]    ber_win_r,  ber_win_nxt_s;
    logic [NB_BER_CNT-1:0]    ber_cnt_r,  ber_cnt_nxt_s, ber_cnt_inc_s;
    logic                     hi_ber_r,   hi_ber_nxt_s;
    logic                     hdr_ok_s;
    logic [NB_WINDOW_CNT-1:0] unlk_lim_s, lk_lim_s;
    logic [NB_INV_SH-1:0]     sh_lim_s;

    // Effective limits (zero behaves as one) and counter increments.
    always_comb begin
        hdr_ok_s   = sh_is_valid(lane_if.sync_header_s);
        unlk_lim_s = (lane_if.unlocked_limit_s == WIN_ZERO) ? WIN_ONE : lane_if.unlocked_limit_s;
        lk_lim_s   = (lane_if.locked_limit_s == WIN_ZERO) ? WIN_ONE : lane_if.locked_limit_s;
        sh_lim_s   = (lane_if.sh_invalid_limit_s == INV_ZERO) ? INV_ONE : lane_if.sh_invalid_limit_s;
        good_inc_s = good_cnt_r + WIN_ONE;
        win_inc_s  = win_cnt_r + WIN_ONE;
        inv_inc_s  = inv_cnt_r + (hdr_ok_s ? INV_ZERO : INV_ONE);
        // BER count saturates at the threshold so it never wraps.
        ber_cnt_inc_s = (!hdr_ok_s && (ber_cnt_r != BCNT_THRESH)) ? (ber_cnt_r + BCNT_ONE) : ber_cnt_r;
    end

    // Lock FSM next state and sync counters.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_cnt_r;
        win_nxt_s   = win_cnt_r;
        inv_nxt_s   = inv_cnt_r;
        if (lane_if.force_unlock_s) begin
            state_nxt_s = ST_UNLOCKED;
            good_nxt_s  = WIN_ZERO;
            win_nxt_s   = WIN_ZERO;
            inv_nxt_s   = INV_ZERO;
        end else if (lane_if.blk_valid_s) begin
            case (state_r)
                ST_UNLOCKED: begin
                    if (!hdr_ok_s) begin
                        good_nxt_s = WIN_ZERO;
                    end else if (good_inc_s >= unlk_lim_s) begin
                        state_nxt_s = ST_LOCKED;
                        good_nxt_s  = WIN_ZERO;
                    end else begin
                        good_nxt_s = good_inc_s;
                    end
                end
                ST_LOCKED: begin
                    // Losing lock takes priority over closing the window.
                    if (inv_inc_s >= sh_lim_s) begin
                        state_nxt_s = ST_UNLOCKED;
                        win_nxt_s   = WIN_ZERO;
                        inv_nxt_s   = INV_ZERO;
                    end else if (win_inc_s >= lk_lim_s) begin
                        win_nxt_s = WIN_ZERO;
                        inv_nxt_s = INV_ZERO;
                    end else begin
                        win_nxt_s = win_inc_s;
                        inv_nxt_s = inv_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_UNLOCKED;
                    good_nxt_s  = WIN_ZERO;
                    win_nxt_s   = WIN_ZERO;
                    inv_nxt_s   = INV_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // BER monitor: counts only blocks seen while already LOCKED.
    always_comb begin
        ber_win_nxt_s = ber_win_r;
        ber_cnt_nxt_s = ber_cnt_r;
        hi_ber_nxt_s  = hi_ber_r;
        if (state_nxt_s != ST_LOCKED) begin
            ber_win_nxt_s = BWIN_ZERO;
            ber_cnt_nxt_s = BCNT_ZERO;
            hi_ber_nxt_s  = 1'b0;
        end else if (lane_if.blk_valid_s && (state_r == ST_LOCKED)) begin
            if (ber_win_r == BWIN_LAST) begin
                hi_ber_nxt_s  = (ber_cnt_inc_s >= BCNT_THRESH);
                ber_win_nxt_s = BWIN_ZERO;
                ber_cnt_nxt_s = BCNT_ZERO;
            end else begin
                ber_win_nxt_s = ber_win_r + BWIN_ONE;
                ber_cnt_nxt_s = ber_cnt_inc_s;
            end
        end else begin
            hi_ber_nxt_s = hi_ber_r;
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_r    <= ST_UNLOCKED;
            good_cnt_r <= WIN_ZERO;
            win_cnt_r  <= WIN_ZERO;
            inv_cnt_r  <= INV_ZERO;
            ber_win_r  <= BWIN_ZERO;
            ber_cnt_r  <= BCNT_ZERO;
            hi_ber_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            good_cnt_r <= good_nxt_s;
            win_cnt_r  <= win_nxt_s;
            inv_cnt_r  <= inv_nxt_s;
            ber_win_r  <= ber_win_nxt_s;
            ber_cnt_r  <= ber_cnt_nxt_s;
            hi_ber_r   <= hi_ber_nxt_s;
        end
    end

    assign lane_if.lane_locked_s   = (state_r == ST_LOCKED);
    assign lane_if.hi_ber_status_s = hi_ber_r;

endmodule

// File: rtl/rx_toplevel.sv
// -----------------------------------------------------------------------------
// rx_toplevel
// Multi-lane PCS receive block-lock / hi-BER monitor.
// Ports:
//   i_clock, i_reset (sync, active low), i_enable   - clock, reset, enable
//   i_phy_data                 - N_LANES blocks, lane k at [k*NB_DATA +: NB_DATA]
//   i_rf_enb_valid_gen         - runs the block-valid strobe generator
//   i_rf_enable_block_sync     - 0 holds every lane UNLOCKED
//   i_rf_*_limit               - lock / window / invalid-header limits
//   i_signal_ok                - 0 holds every lane UNLOCKED
//   i_rf_read_hi_ber           - clear-on-read for o_rf_hi_ber
//   i_rf_read_lanes_block_lock - reload strobe for o_rf_lanes_block_lock
//   o_rf_hi_ber                - latched-high per-lane hi-BER flag
//   o_rf_lanes_block_lock      - latched-low per-lane block lock
// -----------------------------------------------------------------------------
module rx_toplevel
    import pcs_rx_pkg::*;
#(
    parameter int N_LANES                = DEF_N_LANES,
    parameter int NB_DATA                = DEF_NB_DATA,
    parameter int NB_DATA_BUS            = N_LANES * NB_DATA,
    parameter int VALID_COUNT_LIMIT_SLOW = DEF_VALID_COUNT_LIMIT_SLOW,
    parameter int NB_WINDOW_CNT          = DEF_NB_WINDOW_CNT,
    parameter int NB_INV_SH              = DEF_NB_INV_SH,
    parameter int HI_BER_VALUE           = DEF_HI_BER_VALUE,
    parameter int XUS_TIMER_WINDOW       = DEF_XUS_TIMER_WINDOW
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic [NB_DATA_BUS-1:0]   i_phy_data,
    input  logic                     i_rf_enb_valid_gen,
    input  logic                     i_rf_enable_block_sync,
    input  logic [NB_WINDOW_CNT-1:0] i_rf_unlocked_timer_limit,
    input  logic [NB_WINDOW_CNT-1:0] i_rf_locked_timer_limit,
    input  logic [NB_INV_SH-1:0]     i_rf_sh_invalid_limit,
    input  logic                     i_signal_ok,
    input  logic                     i_rf_read_hi_ber,
    input  logic                     i_rf_read_lanes_block_lock,
    output logic [N_LANES-1:0]       o_rf_hi_ber,
    output logic [N_LANES-1:0]       o_rf_lanes_block_lock
);

    localparam int NB_VCNT = (VALID_COUNT_LIMIT_SLOW > 1) ? $clog2(VALID_COUNT_LIMIT_SLOW) : 1;
    localparam logic [NB_VCNT-1:0] VCNT_ZERO = {NB_VCNT{1'b0}};
    localparam logic [NB_VCNT-1:0] VCNT_ONE  = NB_VCNT'(1'b1);
    localparam logic [NB_VCNT-1:0] VCNT_LAST = NB_VCNT'(VALID_COUNT_LIMIT_SLOW - 1);

    logic [NB_VCNT-1:0] vcnt_r, vcnt_nxt_s;
    logic               gen_en_s, blk_valid_s, force_unlock_s;
    logic [N_LANES-1:0] lane_locked_s, lane_hi_ber_s;
    logic [N_LANES-1:0] hi_ber_r, hi_ber_nxt_s, lock_r, lock_nxt_s;
    logic               unused_payload_s;

    // Only the sync headers are consumed here; payload bits are folded away.
    assign unused_payload_s = ^i_phy_data;

    // Block-valid strobe: one clock at the last count of each period.
    always_comb begin
        gen_en_s       = i_enable && i_rf_enb_valid_gen;
        blk_valid_s    = gen_en_s && (vcnt_r == VCNT_LAST);
        force_unlock_s = !i_signal_ok || !i_rf_enable_block_sync;
        if (!gen_en_s) begin
            vcnt_nxt_s = VCNT_ZERO;
        end else if (vcnt_r == VCNT_LAST) begin
            vcnt_nxt_s = VCNT_ZERO;
        end else begin
            vcnt_nxt_s = vcnt_r + VCNT_ONE;
        end
    end

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        rx_toplevel_if #(
            .NB_WINDOW_CNT (NB_WINDOW_CNT),
            .NB_INV_SH     (NB_INV_SH)
        ) lane_if ();

        assign lane_if.blk_valid_s        = blk_valid_s;
        assign lane_if.sync_header_s      = i_phy_data[k*NB_DATA + NB_DATA - 2 +: 2];
        assign lane_if.force_unlock_s     = force_unlock_s;
        assign lane_if.unlocked_limit_s   = i_rf_unlocked_timer_limit;
        assign lane_if.locked_limit_s     = i_rf_locked_timer_limit;
        assign lane_if.sh_invalid_limit_s = i_rf_sh_invalid_limit;
        assign lane_locked_s[k]           = lane_if.lane_locked_s;
        assign lane_hi_ber_s[k]           = lane_if.hi_ber_status_s;

        rx_lane_block_sync #(
            .NB_WINDOW_CNT    (NB_WINDOW_CNT),
            .NB_INV_SH        (NB_INV_SH),
            .HI_BER_VALUE     (HI_BER_VALUE),
            .XUS_TIMER_WINDOW (XUS_TIMER_WINDOW)
        ) u_lane (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .lane_if (lane_if.slave)
        );
    end

    // Clear-on-read status: a live hi-BER status beats a read; a read
    // reloads the current lock, which is also 0 if lock is lost that cycle.
    always_comb begin
        hi_ber_nxt_s = lane_hi_ber_s | (hi_ber_r & ~{N_LANES{i_rf_read_hi_ber}});
        if (i_rf_read_lanes_block_lock) begin
            lock_nxt_s = lane_locked_s;
        end else begin
            lock_nxt_s = lock_r & lane_locked_s;
        end
    end

    // Strobe counter and status registers.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            vcnt_r   <= VCNT_ZERO;
            hi_ber_r <= {N_LANES{1'b0}};
            lock_r   <= {N_LANES{1'b0}};
        end else begin
            vcnt_r   <= vcnt_nxt_s;
            hi_ber_r <= hi_ber_nxt_s;
            lock_r   <= lock_nxt_s;
        end
    end

    assign o_rf_hi_ber           = hi_ber_r;
    assign o_rf_lanes_block_lock = lock_r;

endmodule

// File: tb/tb_rx_toplevel.sv
// -----------------------------------------------------------------------------
// tb_rx_toplevel
// Directed bench for rx_toplevel with 4 lanes, a 2-clock block period and a
// 256-block BER window. Headers are held for whole block periods, so holding
// a pattern for 2*n clocks presents it to exactly n block strobes.
// -----------------------------------------------------------------------------
module tb_rx_toplevel;

    localparam int N_LANES = 4;
    localparam int NB_DATA = 66;
    localparam int NB_BUS  = N_LANES * NB_DATA;
    localparam int VL      = 2;
    localparam int XUS     = 256;

    logic              i_clock = 1'b0;
    logic              i_reset;
    logic              i_enable;
    logic [NB_BUS-1:0] i_phy_data;
    logic              i_rf_enb_valid_gen;
    logic              i_rf_enable_block_sync;
    logic [11:0]       i_rf_unlocked_timer_limit;
    logic [11:0]       i_rf_locked_timer_limit;
    logic [10:0]       i_rf_sh_invalid_limit;
    logic              i_signal_ok;
    logic              i_rf_read_hi_ber;
    logic              i_rf_read_lanes_block_lock;
    logic [N_LANES-1:0] o_rf_hi_ber;
    logic [N_LANES-1:0] o_rf_lanes_block_lock;

    int errors = 0;
    int checks = 0;

    rx_toplevel #(
        .N_LANES                (N_LANES),
        .NB_DATA                (NB_DATA),
        .VALID_COUNT_LIMIT_SLOW (VL),
        .XUS_TIMER_WINDOW       (XUS)
    ) dut (
        .i_clock                    (i_clock),
        .i_reset                    (i_reset),
        .i_enable                   (i_enable),
        .i_phy_data                 (i_phy_data),
        .i_rf_enb_valid_gen         (i_rf_enb_valid_gen),
        .i_rf_enable_block_sync     (i_rf_enable_block_sync),
        .i_rf_unlocked_timer_limit  (i_rf_unlocked_timer_limit),
        .i_rf_locked_timer_limit    (i_rf_locked_timer_limit),
        .i_rf_sh_invalid_limit      (i_rf_sh_invalid_limit),
        .i_signal_ok                (i_signal_ok),
        .i_rf_read_hi_ber           (i_rf_read_hi_ber),
        .i_rf_read_lanes_block_lock (i_rf_read_lanes_block_lock),
        .o_rf_hi_ber                (o_rf_hi_ber),
        .o_rf_lanes_block_lock      (o_rf_lanes_block_lock)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic set_sh(input logic [1:0] s0, input logic [1:0] s1,
                          input logic [1:0] s2, input logic [1:0] s3);
        logic [1:0] sh [N_LANES];
        sh[0] = s0; sh[1] = s1; sh[2] = s2; sh[3] = s3;
        for (int k = 0; k < N_LANES; k++) begin
            i_phy_data[k*NB_DATA +: NB_DATA] = {sh[k], 32'hC0DE_0000 | 32'(k), 32'h1234_5678};
        end
    endtask

    task automatic send_blocks(input int n);
        tick(n * VL);
    endtask

    task automatic freeze();
        i_rf_enb_valid_gen = 1'b0;
        tick(1);
    endtask

    task automatic resume();
        i_rf_enb_valid_gen = 1'b1;
    endtask

    task automatic read_lock();
        i_rf_read_lanes_block_lock = 1'b1;
        tick(1);
        i_rf_read_lanes_block_lock = 1'b0;
        tick(1);
    endtask

    task automatic read_ber();
        i_rf_read_hi_ber = 1'b1;
        tick(1);
        i_rf_read_hi_ber = 1'b0;
        tick(1);
    endtask

    task automatic check(input string tag, input logic [N_LANES-1:0] obs,
                         input logic [N_LANES-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset                    = 1'b0;
        i_enable                   = 1'b1;
        i_rf_enb_valid_gen         = 1'b1;
        i_rf_enable_block_sync     = 1'b1;
        i_rf_unlocked_timer_limit  = 12'd64;
        i_rf_locked_timer_limit    = 12'd1024;
        i_rf_sh_invalid_limit      = 11'd65;
        i_signal_ok                = 1'b1;
        i_rf_read_hi_ber           = 1'b0;
        i_rf_read_lanes_block_lock = 1'b0;
        set_sh(2'b01, 2'b01, 2'b01, 2'b01);
        tick(3);
        check("reset_hi_ber", o_rf_hi_ber, 4'b0000);
        check("reset_lock", o_rf_lanes_block_lock, 4'b0000);

        // Initial lock: 63 good headers are one short, the 64th locks.
        i_reset = 1'b1;
        send_blocks(63);
        freeze();
        read_lock();
        check("lock_after_63", o_rf_lanes_block_lock, 4'b0000);
        resume();
        send_blocks(1);
        freeze();
        read_lock();
        check("lock_after_64", o_rf_lanes_block_lock, 4'b1111);
        check("no_hi_ber_clean", o_rf_hi_ber, 4'b0000);

        // Generator stopped: invalid headers must not disturb lock.
        set_sh(2'b00, 2'b00, 2'b00, 2'b00);
        tick(20);
        read_lock();
        check("frozen_lock", o_rf_lanes_block_lock, 4'b1111);

        // Lane 3 invalid: 64 invalid keep lock, the 65th drops it.
        set_sh(2'b01, 2'b01, 2'b01, 2'b11);
        resume();
        send_blocks(64);
        freeze();
        read_lock();
        check("lane3_64_invalid", o_rf_lanes_block_lock, 4'b1111);
        resume();
        send_blocks(1);
        freeze();
        read_lock();
        check("lane3_65_invalid", o_rf_lanes_block_lock, 4'b0111);
        check("lane3_no_hi_ber", o_rf_hi_ber, 4'b0000);

        // Lane 0: 100 invalid headers inside one BER window -> hi-BER.
        i_rf_sh_invalid_limit = 11'd2000;
        set_sh(2'b00, 2'b01, 2'b01, 2'b01);
        resume();
        send_blocks(100);
        set_sh(2'b10, 2'b10, 2'b10, 2'b10);
        send_blocks(100);
        check("hi_ber_set", o_rf_hi_ber, 4'b0001);
        read_ber();
        check("hi_ber_held_on_read", o_rf_hi_ber, 4'b0001);
        send_blocks(XUS);
        check("hi_ber_latched_clean", o_rf_hi_ber, 4'b0001);
        read_ber();
        check("hi_ber_cleared", o_rf_hi_ber, 4'b0000);
        freeze();
        read_lock();
        check("all_relocked", o_rf_lanes_block_lock, 4'b1111);

        // Signal loss for one clock unlocks every lane.
        i_signal_ok = 1'b0;
        tick(1);
        i_signal_ok = 1'b1;
        tick(1);
        check("sigok_drop_lock", o_rf_lanes_block_lock, 4'b0000);
        read_lock();
        check("sigok_drop_read", o_rf_lanes_block_lock, 4'b0000);

        // Relock; one bad header on lane 0 restarts its good count.
        i_rf_sh_invalid_limit = 11'd65;
        set_sh(2'b01, 2'b01, 2'b01, 2'b01);
        resume();
        send_blocks(40);
        set_sh(2'b00, 2'b01, 2'b01, 2'b01);
        send_blocks(1);
        set_sh(2'b01, 2'b01, 2'b01, 2'b01);
        send_blocks(63);
        freeze();
        read_lock();
        check("relock_lane0_restart", o_rf_lanes_block_lock, 4'b1110);
        resume();
        send_blocks(1);
        freeze();
        read_lock();
        check("relock_lane0_done", o_rf_lanes_block_lock, 4'b1111);

        // Reset while locked clears everything; relock needs 64 fresh blocks.
        i_reset = 1'b0;
        tick(1);
        check("midreset_lock", o_rf_lanes_block_lock, 4'b0000);
        check("midreset_hi_ber", o_rf_hi_ber, 4'b0000);
        i_reset = 1'b1;
        set_sh(2'b10, 2'b10, 2'b10, 2'b10);
        resume();
        send_blocks(63);
        freeze();
        read_lock();
        check("post_reset_63", o_rf_lanes_block_lock, 4'b0000);
        resume();
        send_blocks(1);
        freeze();
        read_lock();
        check("post_reset_64", o_rf_lanes_block_lock, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
